// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register and writeback datapath: waits for load responses,
// aligns/extends load data and drives the register-file write port.
module memwb_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_rd_we,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [1:0]        mem_wb_sel,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic [2:0]        mem_load_funct3,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              flush,
  output logic              wb_busy,
  output logic              wb_w_en,
  output logic [REG_AW-1:0] wb_w_addr,
  output logic [DATA_W-1:0] wb_w_data
);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_WAIT_LOAD = 2'd1;
  localparam logic [1:0] S_DRAIN     = 2'd2;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [1:0]        r_state;
  logic              r_rd_we;
  logic [REG_AW-1:0] r_rd_addr;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_w_en;
  logic [REG_AW-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;

  logic              w_accept;
  logic              w_commit;
  logic              w_capture;
  logic              w_we;
  logic [REG_AW-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [1:0]        w_next_state;

  // Byte/halfword lanes are picked by shifting the word down by the offset.
  function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      3'b010:  return word;
      default: return 32'h0;
    endcase
  endfunction

  assign wb_busy  = (r_state == S_WAIT_LOAD) || (r_state == S_DRAIN);
  assign w_accept = mem_valid && !wb_busy && !flush;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_commit     = 1'b0;
    w_capture    = 1'b0;
    w_we         = mem_rd_we;
    w_addr       = mem_rd_addr;
    w_data       = '0;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          if (mem_wb_sel != SEL_LOAD) begin
            w_commit = 1'b1;
            if (mem_wb_sel == SEL_ALU)      w_data = mem_alu_result;
            else if (mem_wb_sel == SEL_PC4) w_data = mem_pc_plus4;
          end else if (dmem_rvalid) begin
            w_commit = 1'b1;
            w_data   = align_load(mem_load_funct3, mem_alu_result[1:0], dmem_rdata);
          end else begin
            w_capture    = 1'b1;
            w_next_state = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD: begin
        w_we   = r_rd_we;
        w_addr = r_rd_addr;
        w_data = align_load(r_funct3, r_off, dmem_rdata);
        if (dmem_rvalid) begin
          w_commit     = !flush;
          w_next_state = S_RUN;
        end else if (flush) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dmem_rvalid) w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_funct3  <= '0;
      r_off     <= '0;
      r_w_en    <= 1'b0;
      r_w_addr  <= '0;
      r_w_data  <= '0;
    end else begin
      r_state <= w_next_state;
      r_w_en  <= 1'b0;
      if (w_capture) begin
        r_rd_we   <= mem_rd_we;
        r_rd_addr <= mem_rd_addr;
        r_funct3  <= mem_load_funct3;
        r_off     <= mem_alu_result[1:0];
      end
      // Address and data only move on a real write so they hold otherwise.
      if (w_commit && w_we && (w_addr != '0)) begin
        r_w_en   <= 1'b1;
        r_w_addr <= w_addr;
        r_w_data <= w_data;
      end
    end
  end

  assign wb_w_en   = r_w_en;
  assign wb_w_addr = r_w_addr;
  assign wb_w_data = r_w_data;

endmodule

// File: tb/tb_memwb_writeback.sv
// Self-checking bench for memwb_writeback: a scoreboard of expected register
// writes is checked whenever the DUT pulses wb_w_en.
module tb_memwb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_rd_we;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [2:0]  mem_load_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        flush;
  logic        wb_busy;
  logic        wb_w_en;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [36:0] exp_q[$];

  memwb_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
    .mem_pc_plus4(mem_pc_plus4), .mem_load_funct3(mem_load_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .flush(flush),
    .wb_busy(wb_busy), .wb_w_en(wb_w_en), .wb_w_addr(wb_w_addr),
    .wb_w_data(wb_w_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wb_w_en) begin
      logic [36:0] exp;
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wb_w_addr, wb_w_data);
      end else begin
        exp = exp_q.pop_front();
        if ({wb_w_addr, wb_w_data} !== exp) begin
          n_mismatched++;
          $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_w_addr, wb_w_data, exp[36:32], exp[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_rd_we = 0; mem_rd_addr = 0; mem_wb_sel = 0;
    mem_alu_result = 0; mem_pc_plus4 = 0; mem_load_funct3 = 0;
    dmem_rvalid = 0; dmem_rdata = 0; flush = 0;
  endtask

  task automatic present(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [2:0] f3);
    mem_valid = 1; mem_rd_we = 1; mem_rd_addr = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_funct3 = f3;
  endtask

  task automatic expect_en(input string name, input logic exp);
    n_compared++;
    if (wb_w_en !== exp) begin
      n_mismatched++;
      $display("FAIL %s: wb_w_en got %b, required %b", name, wb_w_en, exp);
    end
  endtask

  task automatic expect_busy(input string name, input logic exp);
    n_compared++;
    if (wb_busy !== exp) begin
      n_mismatched++;
      $display("FAIL %s: wb_busy got %b, required %b", name, wb_busy, exp);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_compared++;
    if ({wb_w_en, wb_w_addr, wb_w_data, wb_busy} !== 39'h0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: en=%b addr=%0d data=%h busy=%b, required all 0",
               wb_w_en, wb_w_addr, wb_w_data, wb_busy);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    present(2'b00, 5'd5, 32'h0000_1234, 32'h0, 3'b000);
    exp_q.push_back({5'd5, 32'h0000_1234});
    step();
    mem_valid = 0;
    expect_en("alu_latency", 1'b1);
    step();
    expect_en("alu_pulse_end", 1'b0);
  endtask

  task automatic test_wb_sel();
    present(2'b10, 5'd6, 32'hDEAD_BEEF, 32'h0000_0104, 3'b000);
    exp_q.push_back({5'd6, 32'h0000_0104});
    step();
    expect_en("sel_pc4", 1'b1);
    present(2'b11, 5'd8, 32'hDEAD_BEEF, 32'h0000_0104, 3'b000);
    exp_q.push_back({5'd8, 32'h0});
    step();
    expect_en("sel_reserved", 1'b1);
    mem_valid = 0;
    step();
  endtask

  // Load with its response 'delay' cycles after acceptance (0 = same cycle).
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input int delay, input logic [31:0] exp_data);
    present(2'b01, 5'd10, alu, 32'h0, f3);
    exp_q.push_back({5'd10, exp_data});
    if (delay == 0) begin
      dmem_rvalid = 1; dmem_rdata = rdata;
      step();
    end else begin
      step();
      mem_valid = 0;
      for (int i = 0; i < delay; i++) begin
        expect_busy({name, "_busy"}, 1'b1);
        if (i == delay - 1) begin
          dmem_rvalid = 1; dmem_rdata = rdata;
        end
        step();
      end
    end
    idle_inputs();
    expect_busy({name, "_unbusy"}, 1'b0);
    expect_en({name, "_commit"}, 1'b1);
    step();
  endtask

  task automatic test_loads();
    do_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_0000, 3, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_7FFF, 2, 32'h0000_8001);
    do_load("lw",  3'b010, 32'h0000_2000, 32'h8001_7FFF, 1, 32'h8001_7FFF);
    do_load("f011", 3'b011, 32'h0000_2000, 32'h8001_7FFF, 1, 32'h0);
    do_load("lb_same", 3'b000, 32'h0000_3001, 32'h1234_A5C3, 0, 32'hFFFF_FFA5);
    do_load("lhu_off0", 3'b101, 32'h0000_3000, 32'h1234_A5C3, 0, 32'h0000_A5C3);
  endtask

  task automatic test_x0();
    present(2'b10, 5'd0, 32'h0, 32'h0000_0200, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_en("x0_no_write", 1'b0);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    present(2'b00, 5'd9, 32'h0000_0999, 32'h0, 3'b000);
    flush = 1;
    step();
    idle_inputs();
    expect_en("flush_run_drop", 1'b0);
    present(2'b01, 5'd11, 32'h0000_4000, 32'h0, 3'b010);
    step();
    idle_inputs();
    flush = 1;
    step();
    flush = 0;
    expect_busy("drain_busy0", 1'b1);
    step();
    expect_busy("drain_busy1", 1'b1);
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    expect_busy("drain_done", 1'b0);
    expect_en("drain_no_commit", 1'b0);
    present(2'b01, 5'd12, 32'h0000_4000, 32'h0, 3'b010);
    step();
    idle_inputs();
    flush = 1; dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    step();
    idle_inputs();
    expect_busy("flush_rvalid_run", 1'b0);
    expect_en("flush_rvalid_discard", 1'b0);
    present(2'b00, 5'd7, 32'h0000_0777, 32'h0, 3'b000);
    exp_q.push_back({5'd7, 32'h0000_0777});
    step();
    idle_inputs();
    expect_en("after_flush_alu", 1'b1);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      present(2'b00, 5'(i), 32'h100 + 32'(i), 32'h0, 3'b000);
      exp_q.push_back({5'(i), 32'h100 + 32'(i)});
      step();
      n_compared++;
      if (wb_w_en !== 1'b1 || wb_w_addr !== 5'(i)) begin
        n_mismatched++;
        $display("FAIL b2b_%0d: en=%b addr=%0d, required en=1 addr=%0d", i, wb_w_en, wb_w_addr, i);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_load();
    present(2'b01, 5'd13, 32'h0000_5000, 32'h0, 3'b010);
    step();
    idle_inputs();
    expect_busy("mid_load_busy", 1'b1);
    step();
    rst_n = 0;
    #2;
    n_compared++;
    if ({wb_w_en, wb_w_addr, wb_w_data, wb_busy} !== 39'h0) begin
      n_mismatched++;
      $display("FAIL reset_mid_load: en=%b addr=%0d data=%h busy=%b, required all 0",
               wb_w_en, wb_w_addr, wb_w_data, wb_busy);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0;
    step();
    idle_inputs();
    expect_en("late_rvalid_ignored", 1'b0);
    expect_busy("late_rvalid_busy", 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_wb_sel();
    test_loads();
    test_x0();
    test_flush();
    test_back_to_back();
    test_reset_mid_load();
    step();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/memwb_writeback.md
Name: memwb_writeback

Overview:
- Final pipeline stage of the RISC-V core: the MEM/WB pipeline register plus the writeback datapath.
- Holds the instruction leaving MEM, waits for the data-memory load response when needed, aligns and sign-/zero-extends load data, and selects the writeback source.
- Drives the register file write port (wb_w_en / wb_w_addr / wb_w_data), which the register file samples on the rising clock edge.
- Back-pressures MEM while a load response is outstanding.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width (x0..x31).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  MEM stage presents an instruction this cycle.
- mem_rd_we  in  1  instruction writes rd.
- mem_rd_addr  in  5  destination register.
- mem_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- mem_alu_result  in  32  ALU result; for loads, the effective address.
- mem_pc_plus4  in  32  PC+4, used for JAL/JALR.
- mem_load_funct3  in  3  load type.
- dmem_rvalid  in  1  data-memory read response valid (one-cycle pulse).
- dmem_rdata  in  32  data-memory read word (word-aligned).
- flush  in  1  kill the instruction in MEM and any pending load.
- wb_busy  out  1  stall request to MEM; MEM holds its instruction while high.
- wb_w_en  out  1  register file write enable.
- wb_w_addr  out  5  register file write address.
- wb_w_data  out  32  register file write data.

Behaviour:
- Reset: state=RUN; wb_w_en=0, wb_w_addr=0, wb_w_data=0, wb_busy=0; all internal holding registers cleared. Asserting rst_n mid-load drops the load; any later dmem_rvalid is ignored, because the FSM is in RUN with nothing pending.
- wb_busy is combinational: 1 iff state is WAIT_LOAD or DRAIN.
- Acceptance: an instruction is accepted when mem_valid=1, wb_busy=0 and flush=0.
- wb_w_en is a registered one-cycle pulse; default 0 in every cycle without a commit. wb_w_addr and wb_w_data hold their last values when wb_w_en=0.
- Commit value: wb_w_en <= rd_we && (rd_addr != 0). Writes to x0 never pulse wb_w_en.
- State RUN:
  - Accepted non-load (sel 00/10/11): next edge commits; wb_w_data = alu_result (00), pc_plus4 (10), or 0 (11). Latency is 1 cycle from acceptance to wb_w_en.
  - Accepted load with dmem_rvalid=1 in the same cycle: commits the aligned data at the next edge, staying in RUN.
  - Accepted load with dmem_rvalid=0: latch rd_we, rd_addr, funct3 and byte offset (alu_result[1:0]), then go to WAIT_LOAD.
  - dmem_rvalid with no pending load: ignored.
- State WAIT_LOAD:
  - mem_valid is ignored (MEM is stalled).
  - dmem_rvalid=1 and flush=0: commit the aligned data at the edge; go to RUN.
  - flush=1 and dmem_rvalid=0: go to DRAIN.
  - flush=1 and dmem_rvalid=1 together: discard the data and go to RUN.
- State DRAIN: wait for dmem_rvalid, discard it, go to RUN. No commit. flush has no further effect here.
- flush in RUN: the instruction presented this cycle is not accepted. A commit already registered in the previous cycle is unaffected.
- Load alignment (off = byte offset):
  - LB(000): byte at off, sign-extended.
  - LBU(100): byte at off, zero-extended.
  - LH(001): halfword at off[1], sign-extended.
  - LHU(101): halfword at off[1], zero-extended.
  - LW(010): full word.
  - 011, 110, 111: data 0, write still committed.
  - Misalignment is not checked here; it is trapped in MEM.
- Back-to-back: in RUN, a new instruction may be accepted every cycle, so wb_w_en may be high on consecutive cycles.

Test Plan:
- Reset, then mem_valid with sel=00, rd=5, alu=0x0000_1234 → one cycle later wb_w_en=1, wb_w_addr=5, wb_w_data=0x0000_1234; next cycle wb_w_en=0.
- Load LB, alu=0x1003, dmem_rvalid three cycles later with rdata=0x80FF_0000 → wb_busy=1 for three cycles; then wb_w_data=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- LH at off=2 with rdata=0x8001_7FFF → 0xFFFF_8001; LHU → 0x0000_8001; LW → 0x8001_7FFF; funct3=011 → 0.
- Instruction with rd=0 and rd_we=1, sel=10 → wb_w_en stays 0 for all cycles.
- Load pending, flush asserted, dmem_rvalid two cycles later → no commit; wb_busy stays high until that rvalid, then drops to 0; the next ALU instruction commits normally.
- Three back-to-back ALU instructions rd=1/2/3 → three consecutive wb_w_en pulses with matching addresses; rst_n asserted during WAIT_LOAD → all outputs 0 and a late dmem_rvalid causes no write.
